// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard unit signal bundle.
//   master : pipeline side; drives stage register addresses/qualifiers, receives
//            forwarding selects, stall/flush controls and mult/div status.
//   slave  : hazard unit side (hazard_ctrl).
interface hazard_ctrl_if #(
  parameter int unsigned RF_ADDR_WIDTH = 5
);
  // Decode-stage sources
  logic [RF_ADDR_WIDTH-1:0] i_RsD;
  logic [RF_ADDR_WIDTH-1:0] i_RtD;
  // Execute-stage sources and destination
  logic [RF_ADDR_WIDTH-1:0] i_RsE;
  logic [RF_ADDR_WIDTH-1:0] i_RtE;
  logic [RF_ADDR_WIDTH-1:0] i_WriteRegE;
  // Memory / writeback destinations
  logic [RF_ADDR_WIDTH-1:0] i_WriteRegM;
  logic [RF_ADDR_WIDTH-1:0] i_WriteRegW;
  // Write / load qualifiers
  logic i_RegWriteE;
  logic i_RegWriteM;
  logic i_RegWriteW;
  logic i_MemtoRegE;
  logic i_MemtoRegM;
  // Decode-stage control flow
  logic i_BranchD;
  logic i_JumpRegD;
  logic i_PCSrcD;
  // Mult/div
  logic i_MDStartE;
  logic i_MDUseD;
  // Outputs
  logic       o_ForwardAD;
  logic       o_ForwardBD;
  logic [1:0] o_ForwardAE;
  logic [1:0] o_ForwardBE;
  logic       o_StallF;
  logic       o_StallD;
  logic       o_FlushD;
  logic       o_FlushE;
  logic       o_MDBusy;
  logic       o_MDDone;

  modport master (
    output i_RsD, i_RtD, i_RsE, i_RtE, i_WriteRegE, i_WriteRegM, i_WriteRegW,
    output i_RegWriteE, i_RegWriteM, i_RegWriteW, i_MemtoRegE, i_MemtoRegM,
    output i_BranchD, i_JumpRegD, i_PCSrcD, i_MDStartE, i_MDUseD,
    input  o_ForwardAD, o_ForwardBD, o_ForwardAE, o_ForwardBE,
    input  o_StallF, o_StallD, o_FlushD, o_FlushE, o_MDBusy, o_MDDone
  );

  modport slave (
    input  i_RsD, i_RtD, i_RsE, i_RtE, i_WriteRegE, i_WriteRegM, i_WriteRegW,
    input  i_RegWriteE, i_RegWriteM, i_RegWriteW, i_MemtoRegE, i_MemtoRegM,
    input  i_BranchD, i_JumpRegD, i_PCSrcD, i_MDStartE, i_MDUseD,
    output o_ForwardAD, o_ForwardBD, o_ForwardAE, o_ForwardBE,
    output o_StallF, o_StallD, o_FlushD, o_FlushE, o_MDBusy, o_MDDone
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard unit for a 5-stage pipeline: operand forwarding (decode comparator and
// ALU), load-use / branch / mult-div stalls, decode flush on redirect, and a
// busy/done tracker for a fixed-latency multiply/divide unit.
// Ports:
//   i_CLK : clock, rising edge
//   i_RST : synchronous active-high reset; forces all outputs low while high
//   hz    : hazard_ctrl_if slave modport (pipeline inputs, control outputs)
module hazard_ctrl #(
  parameter int unsigned RF_ADDR_WIDTH = 5,
  parameter int unsigned MD_LATENCY    = 32  // legal 2..255
) (
  input  logic          i_CLK,
  input  logic          i_RST,
  hazard_ctrl_if.slave  hz
);

  localparam logic [RF_ADDR_WIDTH-1:0] RegZero = '0;
  localparam logic [7:0] CntLoad = 8'(MD_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} md_state_e;

  md_state_e  state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic       md_busy, md_done;
  logic       fwd_ad, fwd_bd;
  logic [1:0] fwd_ae, fwd_be;
  logic       lwstall, brstall, mdstall, stall;

  // ---------------------------------------------------------------------------
  // Mult/div FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state. A start seen while busy is dropped: the unit is not restartable.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (hz.i_MDStartE) begin
          state_d = StBusy;
          cnt_d   = CntLoad;
        end
      end
      StBusy: begin
        if (cnt_q == 8'd0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StDone: begin
        if (hz.i_MDStartE) begin
          state_d = StBusy;
          cnt_d   = CntLoad;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded purely from the registered state.
  always_comb begin
    md_busy = 1'b0;
    md_done = 1'b0;
    unique case (state_q)
      StBusy:  md_busy = 1'b1;
      StDone:  md_done = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Forwarding
  // ---------------------------------------------------------------------------
  always_comb begin
    fwd_ad = (hz.i_RsD != RegZero) && (hz.i_RsD == hz.i_WriteRegM) && hz.i_RegWriteM;
    fwd_bd = (hz.i_RtD != RegZero) && (hz.i_RtD == hz.i_WriteRegM) && hz.i_RegWriteM;

    // Memory stage holds the younger result, so it wins over writeback.
    if ((hz.i_RsE != RegZero) && (hz.i_RsE == hz.i_WriteRegM) && hz.i_RegWriteM) begin
      fwd_ae = 2'b10;
    end else if ((hz.i_RsE != RegZero) && (hz.i_RsE == hz.i_WriteRegW) && hz.i_RegWriteW) begin
      fwd_ae = 2'b01;
    end else begin
      fwd_ae = 2'b00;
    end

    if ((hz.i_RtE != RegZero) && (hz.i_RtE == hz.i_WriteRegM) && hz.i_RegWriteM) begin
      fwd_be = 2'b10;
    end else if ((hz.i_RtE != RegZero) && (hz.i_RtE == hz.i_WriteRegW) && hz.i_RegWriteW) begin
      fwd_be = 2'b01;
    end else begin
      fwd_be = 2'b00;
    end
  end

  // ---------------------------------------------------------------------------
  // Stalls
  // ---------------------------------------------------------------------------
  always_comb begin
    lwstall = hz.i_MemtoRegE && ((hz.i_RtE == hz.i_RsD) || (hz.i_RtE == hz.i_RtD));

    // Branches compare Rs and Rt in decode; jr only reads Rs.
    brstall = (hz.i_BranchD || hz.i_JumpRegD) &&
              ((hz.i_RegWriteE && (hz.i_WriteRegE != RegZero) &&
                ((hz.i_WriteRegE == hz.i_RsD) ||
                 (hz.i_BranchD && (hz.i_WriteRegE == hz.i_RtD)))) ||
               (hz.i_MemtoRegM && (hz.i_WriteRegM != RegZero) &&
                ((hz.i_WriteRegM == hz.i_RsD) ||
                 (hz.i_BranchD && (hz.i_WriteRegM == hz.i_RtD)))));

    // A start in E counts as busy so back-to-back HI/LO users also wait.
    mdstall = hz.i_MDUseD && (md_busy || hz.i_MDStartE);

    stall = lwstall || brstall || mdstall;
  end

  // ---------------------------------------------------------------------------
  // Output drive; everything held low during reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    hz.o_ForwardAD = ~i_RST & fwd_ad;
    hz.o_ForwardBD = ~i_RST & fwd_bd;
    hz.o_ForwardAE = i_RST ? 2'b00 : fwd_ae;
    hz.o_ForwardBE = i_RST ? 2'b00 : fwd_be;
    hz.o_StallF    = ~i_RST & stall;
    hz.o_StallD    = ~i_RST & stall;
    hz.o_FlushE    = ~i_RST & stall;
    // Redirect is only honoured once the decode instruction actually advances.
    hz.o_FlushD    = ~i_RST & hz.i_PCSrcD & ~stall;
    hz.o_MDBusy    = ~i_RST & md_busy;
    hz.o_MDDone    = ~i_RST & md_done;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  localparam int unsigned AW  = 5;
  localparam int unsigned LAT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.RF_ADDR_WIDTH(AW)) hz ();

  hazard_ctrl #(.RF_ADDR_WIDTH(AW), .MD_LATENCY(LAT)) dut (
    .i_CLK (clk),
    .i_RST (rst),
    .hz    (hz.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string      name;
    logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw;
    logic       rwe, rwm, rww, mre, mrm, br, jr, pcsrc, mduse;
    logic       e_fad, e_fbd;
    logic [1:0] e_fae, e_fbe;
    logic       e_stall, e_flushd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr();
    hz.i_RsD = '0; hz.i_RtD = '0; hz.i_RsE = '0; hz.i_RtE = '0;
    hz.i_WriteRegE = '0; hz.i_WriteRegM = '0; hz.i_WriteRegW = '0;
    hz.i_RegWriteE = 0; hz.i_RegWriteM = 0; hz.i_RegWriteW = 0;
    hz.i_MemtoRegE = 0; hz.i_MemtoRegM = 0;
    hz.i_BranchD = 0; hz.i_JumpRegD = 0; hz.i_PCSrcD = 0;
    hz.i_MDStartE = 0; hz.i_MDUseD = 0;
  endtask

  function automatic vec_t mk(input string name,
      input logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw,
      input logic rwe, rwm, rww, mre, mrm, br, jr, pcsrc, mduse,
      input logic fad, fbd, input logic [1:0] fae, fbe, input logic st, fd);
    vec_t v;
    v.name = name; v.rsd = rsd; v.rtd = rtd; v.rse = rse; v.rte = rte;
    v.wre = wre; v.wrm = wrm; v.wrw = wrw; v.rwe = rwe; v.rwm = rwm; v.rww = rww;
    v.mre = mre; v.mrm = mrm; v.br = br; v.jr = jr; v.pcsrc = pcsrc; v.mduse = mduse;
    v.e_fad = fad; v.e_fbd = fbd; v.e_fae = fae; v.e_fbe = fbe;
    v.e_stall = st; v.e_flushd = fd;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    hz.i_RsD = v.rsd; hz.i_RtD = v.rtd; hz.i_RsE = v.rse; hz.i_RtE = v.rte;
    hz.i_WriteRegE = v.wre; hz.i_WriteRegM = v.wrm; hz.i_WriteRegW = v.wrw;
    hz.i_RegWriteE = v.rwe; hz.i_RegWriteM = v.rwm; hz.i_RegWriteW = v.rww;
    hz.i_MemtoRegE = v.mre; hz.i_MemtoRegM = v.mrm;
    hz.i_BranchD = v.br; hz.i_JumpRegD = v.jr; hz.i_PCSrcD = v.pcsrc;
    hz.i_MDUseD = v.mduse; hz.i_MDStartE = 0;
  endtask

  // Check MD outputs and stall in the current cycle (called mid-cycle).
  task automatic chk_md(input string tag, input logic busy, input logic done, input logic st);
    chk({tag, ".busy"},  32'(hz.o_MDBusy), 32'(busy));
    chk({tag, ".done"},  32'(hz.o_MDDone), 32'(done));
    chk({tag, ".stall"}, 32'(hz.o_StallD), 32'(st));
  endtask

  // Drive a start pulse in "cycle 0"; returns at the start of cycle 1 (edge + 1).
  task automatic md_start(input logic use_d);
    @(posedge clk); #1;
    hz.i_MDStartE = 1; hz.i_MDUseD = use_d;
    #4 chk_md("md.c0", 1'b0, 1'b0, use_d);
    @(posedge clk); #1;
    hz.i_MDStartE = 0;
  endtask

  initial begin
    //                  name       rsd rtd rse rte wre wrm wrw rwe rwm rww mre mrm br jr pc mu  fad fbd fae    fbe   st fd
    vecs.push_back(mk("zero",     0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0, 0,  0,  0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("fwdM_pri", 0,  0,  3,  0,  0,  3,  3,  0,  1,  1,  0,  0,  0, 0, 0, 0,  0,  0, 2'b10, 2'b00, 0, 0));
    vecs.push_back(mk("fwd_r0",   0,  0,  0,  0,  0,  3,  3,  0,  1,  1,  0,  0,  0, 0, 0, 0,  0,  0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("fwd_mix",  5,  4,  4,  5,  0,  5,  4,  0,  1,  1,  0,  0,  0, 0, 0, 0,  1,  0, 2'b01, 2'b10, 0, 0));
    vecs.push_back(mk("fwdW_off", 0,  0,  4,  0,  0,  0,  4,  0,  0,  0,  0,  0,  0, 0, 0, 0,  0,  0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("fwdBD",    0,  9,  0,  0,  0,  9,  0,  0,  1,  0,  0,  0,  0, 0, 0, 0,  0,  1, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("lw_rs",    5,  0,  0,  5,  0,  0,  0,  0,  0,  0,  1,  0,  0, 0, 1, 0,  0,  0, 2'b00, 2'b00, 1, 0));
    vecs.push_back(mk("lw_rt",    1,  9,  0,  9,  0,  0,  0,  0,  0,  0,  1,  0,  0, 0, 0, 0,  0,  0, 2'b00, 2'b00, 1, 0));
    vecs.push_back(mk("lw_r0",    0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  1,  0,  0, 0, 0, 0,  0,  0, 2'b00, 2'b00, 1, 0));
    vecs.push_back(mk("redirect", 0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0, 0, 1, 0,  0,  0, 2'b00, 2'b00, 0, 1));
    vecs.push_back(mk("br_rtE",   0,  7,  0,  0,  7,  0,  0,  1,  0,  0,  0,  0,  1, 0, 0, 0,  0,  0, 2'b00, 2'b00, 1, 0));
    vecs.push_back(mk("jr_rt",    2,  7,  0,  0,  7,  0,  0,  1,  0,  0,  0,  0,  0, 1, 1, 0,  0,  0, 2'b00, 2'b00, 0, 1));
    vecs.push_back(mk("jr_rs",    2,  0,  0,  0,  2,  0,  0,  1,  0,  0,  0,  0,  0, 1, 0, 0,  0,  0, 2'b00, 2'b00, 1, 0));
    vecs.push_back(mk("br_ldM",   6,  0,  0,  0,  0,  6,  0,  0,  1,  0,  0,  1,  1, 0, 0, 0,  1,  0, 2'b00, 2'b00, 1, 0));
    vecs.push_back(mk("br_r0",    0,  0,  0,  0,  0,  0,  0,  1,  0,  0,  0,  0,  1, 0, 1, 0,  0,  0, 2'b00, 2'b00, 0, 1));
    vecs.push_back(mk("nobr",     7,  0,  0,  0,  7,  0,  0,  1,  0,  0,  0,  0,  0, 0, 0, 0,  0,  0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("md_idle",  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0, 1,  0,  0, 2'b00, 2'b00, 0, 0));

    clr();
    rst = 1;
    // Reset with hazard-provoking inputs: every output must stay low.
    apply(vecs[3]);
    hz.i_MemtoRegE = 1; hz.i_PCSrcD = 1; hz.i_RtE = 5;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.fae",   32'(hz.o_ForwardAE), 32'd0);
    chk("rst.fbe",   32'(hz.o_ForwardBE), 32'd0);
    chk("rst.fad",   32'(hz.o_ForwardAD), 32'd0);
    chk("rst.stall", 32'({hz.o_StallF, hz.o_StallD, hz.o_FlushE}), 32'd0);
    chk("rst.flush", 32'(hz.o_FlushD), 32'd0);
    chk("rst.md",    32'({hz.o_MDBusy, hz.o_MDDone}), 32'd0);
    clr();
    @(posedge clk); #1;
    rst = 0;

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      apply(vecs[i]);
      #4;
      chk({vecs[i].name, ".fad"},    32'(hz.o_ForwardAD), 32'(vecs[i].e_fad));
      chk({vecs[i].name, ".fbd"},    32'(hz.o_ForwardBD), 32'(vecs[i].e_fbd));
      chk({vecs[i].name, ".fae"},    32'(hz.o_ForwardAE), 32'(vecs[i].e_fae));
      chk({vecs[i].name, ".fbe"},    32'(hz.o_ForwardBE), 32'(vecs[i].e_fbe));
      chk({vecs[i].name, ".stallF"}, 32'(hz.o_StallF),    32'(vecs[i].e_stall));
      chk({vecs[i].name, ".stallD"}, 32'(hz.o_StallD),    32'(vecs[i].e_stall));
      chk({vecs[i].name, ".flushE"}, 32'(hz.o_FlushE),    32'(vecs[i].e_stall));
      chk({vecs[i].name, ".flushD"}, 32'(hz.o_FlushD),    32'(vecs[i].e_flushd));
    end
    clr();

    // Basic latency: busy cycles 1..4, done 5, idle 6; MDUseD stalls 0..4.
    md_start(1'b1);
    for (int c = 1; c <= 6; c++) begin
      #4 chk_md($sformatf("md.c%0d", c), 1'(c >= 1 && c <= LAT), 1'(c == LAT + 1),
                1'(c <= LAT));
      @(posedge clk); #1;
    end
    clr();

    // Start during busy is ignored; done still on cycle 5.
    md_start(1'b0);
    for (int c = 1; c <= 6; c++) begin
      hz.i_MDStartE = (c == 2);
      #4 chk_md($sformatf("ign.c%0d", c), 1'(c <= LAT), 1'(c == LAT + 1), 1'b0);
      @(posedge clk); #1;
    end
    clr();

    // Reset mid-busy (cycle 3): idle afterwards, no done pulse.
    md_start(1'b0);
    for (int c = 1; c <= 8; c++) begin
      rst = (c == 3);
      #4 chk_md($sformatf("rst.c%0d", c), 1'(c <= 2), 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    rst = 0;
    clr();

    // Start in the done cycle reloads: busy 6..9, done 10.
    md_start(1'b0);
    for (int c = 1; c <= 11; c++) begin
      hz.i_MDStartE = (c == LAT + 1);
      #4 chk_md($sformatf("rel.c%0d", c), 1'((c <= LAT) || (c >= LAT + 2 && c <= 2 * LAT + 1)),
                1'(c == LAT + 1 || c == 2 * LAT + 2), 1'b0);
      @(posedge clk); #1;
    end
    clr();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter RF_ADDR_WIDTH, default 5: register-address width.
REQ-002 SHALL have parameter MD_LATENCY, default 32: multiply/divide busy cycles; legal range 2..255.
REQ-003 SHALL have port i_CLK, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_RST, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have ports i_RsD, i_RtD, input, RF_ADDR_WIDTH: source registers of the decode-stage instruction.
REQ-006 SHALL have ports i_RsE, i_RtE, i_WriteRegE, input, RF_ADDR_WIDTH: execute-stage sources and destination.
REQ-007 SHALL have ports i_WriteRegM, i_WriteRegW, input, RF_ADDR_WIDTH: memory- and writeback-stage destinations.
REQ-008 SHALL have ports i_RegWriteE, i_RegWriteM, i_RegWriteW, i_MemtoRegE, i_MemtoRegM, input, 1: pipeline write/load qualifiers.
REQ-009 SHALL have ports i_BranchD, i_JumpRegD, i_PCSrcD, input, 1: decode-stage branch, jr, redirect taken.
REQ-010 SHALL have ports i_MDStartE, i_MDUseD, input, 1: mult/div issued in E; D instruction reads HI/LO or starts mult/div.
REQ-011 SHALL have ports o_ForwardAD, o_ForwardBD, output, 1: decode comparator forward from ALUOutM.
REQ-012 SHALL have ports o_ForwardAE, o_ForwardBE, output, 2: ALU operand select (00 RF, 01 ResultW, 10 ALUOutM).
REQ-013 SHALL have ports o_StallF, o_StallD, o_FlushD, o_FlushE, output, 1: pipeline register controls.
REQ-014 SHALL have ports o_MDBusy, o_MDDone, output, 1: multiply/divide unit busy level; one-cycle completion pulse.

Function
REQ-015 o_ForwardAD SHALL = (i_RsD!=0) & (i_RsD==i_WriteRegM) & i_RegWriteM; o_ForwardBD likewise with i_RtD.
REQ-016 o_ForwardAE SHALL = 10 if i_RsE!=0 & i_RsE==i_WriteRegM & i_RegWriteM; else 01 if i_RsE!=0 & i_RsE==i_WriteRegW & i_RegWriteW; else 00. M priority over W. o_ForwardBE likewise with i_RtE.
REQ-017 lwstall SHALL = i_MemtoRegE & (i_RtE==i_RsD | i_RtE==i_RtD).
REQ-018 brstall SHALL = (i_BranchD|i_JumpRegD) & ((i_RegWriteE & i_WriteRegE!=0 & (i_WriteRegE==i_RsD | (i_BranchD & i_WriteRegE==i_RtD))) | (i_MemtoRegM & i_WriteRegM!=0 & (i_WriteRegM==i_RsD | (i_BranchD & i_WriteRegM==i_RtD)))); jr checks Rs only.
REQ-019 mdstall SHALL = i_MDUseD & (o_MDBusy | i_MDStartE).
REQ-020 stall = lwstall|brstall|mdstall; o_StallF = o_StallD = o_FlushE = stall.
REQ-021 o_FlushD SHALL = i_PCSrcD & ~stall (redirect only on non-stalled cycle).
REQ-022 MD FSM states IDLE, BUSY, DONE; 8-bit down-counter cnt.
REQ-023 IDLE: i_MDStartE -> BUSY, cnt=MD_LATENCY-1; else stay.
REQ-024 BUSY: cnt!=0 -> cnt-1; cnt==0 -> DONE. o_MDBusy=1 exactly MD_LATENCY cycles.
REQ-025 DONE: o_MDDone=1 one cycle; i_MDStartE -> BUSY (reload), else IDLE.
REQ-026 i_MDStartE in BUSY SHALL be ignored (no restart, cnt unaffected).
REQ-027 o_MDBusy, o_MDDone SHALL be decoded from registered state only; forwarding/stall outputs combinational.

Reset
REQ-028 i_RST=1 at a clock edge SHALL force IDLE, cnt=0, including mid-BUSY; pending operation discarded, no o_MDDone.
REQ-029 While i_RST=1, all outputs SHALL be 0 (forward selects 00, no stall/flush).

Verification
REQ-030 RsE=3, WriteRegM=3, RegWriteM=1, WriteRegW=3, RegWriteW=1 -> ForwardAE=10; RsE=0 same -> 00.
REQ-031 MemtoRegE=1, RtE=5, RsD=5 -> StallF=StallD=FlushE=1, FlushD=0 even with PCSrcD=1.
REQ-032 BranchD=1, RegWriteE=1, WriteRegE=7, RtD=7 -> stall=1; JumpRegD=1 instead, RsD=2 -> stall=0.
REQ-033 MD_LATENCY=4, MDStartE pulse at edge 0 -> MDBusy high cycles 1-4, MDDone cycle 5, IDLE cycle 6; MDUseD=1 stalls cycles 0-4 only.
REQ-034 MDStartE at cycle 2 of BUSY -> ignored, MDDone still cycle 5; i_RST at cycle 3 -> IDLE next cycle, no MDDone.
